logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined bitwise logic unit: WIDTH-bit A/B operands, 3-bit op select (OR/AND/XOR/inverts/pass).

---
 rtl/logic_unit_pkg.sv | 17 +
 rtl/logic_unit_stage.sv | 33 +++
 rtl/logic_unit_pipe.sv | 85 ++++++++
 tb/tb_logic_unit_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
package logic_unit_pkg;

    localparam int unsigned OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_AND    = 3'b000;
    localparam op_t OP_OR     = 3'b001;
    localparam op_t OP_XOR    = 3'b010;
    localparam op_t OP_NAND   = 3'b011;
    localparam op_t OP_NOR    = 3'b100;
    localparam op_t OP_XNOR   = 3'b101;
    localparam op_t OP_PASS_A = 3'b110;
    localparam op_t OP_NOT_A  = 3'b111;

endpackage

// File: rtl/logic_unit_stage.sv
// One pipeline register: valid bit plus payload, advancing only when enabled.
module logic_unit_stage #(
    parameter int unsigned DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    output logic          valid_out,
    output logic [DW-1:0] data_out
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // Bubbles advance the valid bit but leave the payload untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en) begin
            valid_q <= valid_in;
            if (valid_in) begin
                data_q <= data_in;
            end
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined multi-op bitwise logic unit with valid/ready flow control,
// result reductions and a wrapping hand-off counter.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_any,
    output logic             y_all,
    output logic [CNT_W-1:0] done_cnt
);

    // Payload layout: {y_all, y_any, y}
    localparam int unsigned DW = WIDTH + 2;

    function automatic logic [WIDTH-1:0] op_eval(input op_t sel, input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] r;
        r = '0;
        unique case (sel)
            OP_AND:    r = x & z;
            OP_OR:     r = x | z;
            OP_XOR:    r = x ^ z;
            OP_NAND:   r = ~(x & z);
            OP_NOR:    r = ~(x | z);
            OP_XNOR:   r = ~(x ^ z);
            OP_PASS_A: r = x;
            OP_NOT_A:  r = ~x;
        endcase
        return r;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] y_new;
    logic             stage_valid [STAGES+1];
    logic [DW-1:0]    stage_data  [STAGES+1];
    logic [CNT_W-1:0] done_cnt_q;

    assign y_new          = op_eval(op_t'(op), a, b);
    assign stage_valid[0] = in_valid;
    assign stage_data[0]  = {&y_new, |y_new, y_new};

    // Stall-all pipeline: every stage shares one enable.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic_unit_stage #(
            .DW (DW)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (adv),
            .valid_in  (stage_valid[i]),
            .data_in   (stage_data[i]),
            .valid_out (stage_valid[i+1]),
            .data_out  (stage_data[i+1])
        );
    end

    assign out_valid            = stage_valid[STAGES];
    assign {y_all, y_any, y}    = stage_data[STAGES];
    assign adv                  = !out_valid || out_ready;
    assign in_ready             = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt_q <= done_cnt_q + CNT_W'(1);
        end
    end

    assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: truth-table model, scoreboard queue, directed and
// randomized traffic.
module tb_logic_unit_pipe;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 3;
    localparam int unsigned CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       op = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] y;
    logic             y_any;
    logic             y_all;
    logic [CNT_W-1:0] done_cnt;

    logic_unit_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_any     (y_any),
        .y_all     (y_all),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH+1:0] got_log[$];
    int               model_cnt = 0;
    int               run = 0;
    int               best_run = 0;
    logic             prev_stall = 1'b0;
    logic [WIDTH+1:0] prev_out = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
        logic [3:0]       tt;
        logic [WIDTH-1:0] r;
        case (o)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0111;
            3'd4:    tt = 4'b0001;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b1100;
            default: tt = 4'b0011;
        endcase
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = tt[{x[i], z[i]}];
        end
        return r;
    endfunction

    // Compare process: scoreboard, flow-control and hold checks every cycle.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_done_cnt", 32'(done_cnt), 32'd0);
            chk("rst_y", 32'({y_all, y_any, y}), 32'd0);
            exp_q.delete();
            model_cnt  = 0;
            run        = 0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            chk("done_cnt", 32'(done_cnt), 32'(model_cnt % (1 << CNT_W)));
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'({y_all, y_any, y}), 32'(prev_out));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("y", 32'(y), 32'(e));
                    chk("y_any", 32'(y_any), 32'(e != '0));
                    chk("y_all", 32'(y_all), 32'(e == '1));
                end
                got_log.push_back({y_all, y_any, y});
                model_cnt++;
                run++;
                if (run > best_run) best_run = run;
            end else begin
                run = 0;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_op(op, a, b));
            prev_stall = out_valid && !out_ready;
            prev_out   = {y_all, y_any, y};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (STAGES + 3) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = z;
        tick();
    endtask

    logic [2:0]       dir_op [11] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                      3'd1, 3'd1, 3'd0};
    logic [WIDTH-1:0] dir_a  [11] = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
                                      8'h00, 8'hFF, 8'h5A};
    logic [WIDTH-1:0] dir_b  [11] = '{8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC,
                                      8'h00, 8'h00, 8'h5A};
    logic [WIDTH+1:0] dir_lit[11] = '{10'h1C0, 10'h1FC, 10'h13C, 10'h13F, 10'h103, 10'h1C3,
                                      10'h1F0, 10'h10F, 10'h000, 10'h3FF, 10'h15A};

    initial begin
        logic taken;
        repeat (2) tick();
        chk("reset_y_any", 32'(y_any), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // All ops on F0/CC plus reduction corner cases.
        got_log.delete();
        for (int i = 0; i < 11; i++) send(dir_op[i], dir_a[i], dir_b[i]);
        drain();
        chk("lit_count", 32'(got_log.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (got_log.size() > i) chk($sformatf("lit_%0d", i), 32'(got_log[i]), 32'(dir_lit[i]));
        end

        // Latency: accepted at edge N, visible after edge N+2.
        send(3'd1, 8'h12, 8'h34);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_n", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_n1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_n2", 32'(out_valid), 32'd1);
        chk("lat_y", 32'(y), 32'h36);
        tick();
        drain();

        // Streaming 10 beats back to back.
        do_reset();
        best_run = 0;
        for (int i = 0; i < 10; i++) send(3'($urandom), 8'($urandom), 8'($urandom));
        drain();
        chk("stream_run", 32'(best_run), 32'd10);
        chk("stream_cnt", 32'(done_cnt), 32'd10);

        // Backpressure with full pipe and a held fourth beat.
        got_log.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(3'd2, 8'(i * 17), 8'hA5);
        send(3'd5, 8'h3C, 8'h99);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        drain();
        chk("bp_count", 32'(got_log.size()), 32'd4);

        // Counter wrap at 2^CNT_W.
        do_reset();
        for (int i = 0; i < 17; i++) send(3'($urandom), 8'($urandom), 8'($urandom));
        drain();
        chk("wrap_cnt", 32'(done_cnt), 32'd1);

        // Reset with two beats in flight.
        send(3'd3, 8'h11, 8'h22);
        send(3'd4, 8'h33, 8'h44);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_done_cnt", 32'(done_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        got_log.delete();
        for (int i = 0; i < STAGES + 3; i++) begin
            tick();
            chk("no_stale_valid", 32'(out_valid), 32'd0);
        end
        chk("no_stale_count", 32'(got_log.size()), 32'd0);

        // Randomized traffic; source holds an untaken beat.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            taken = in_valid && in_ready;
            tick();
            if (!in_valid || taken) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a  = 8'($urandom);
                b  = 8'($urandom);
                op = 3'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        taken = in_valid && in_ready;
        tick();
        if (!taken) in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
